// File: rtl/bist_pkg.sv
// Shared types, polynomials and step functions for the scan BIST controller.
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE
  } bist_state_e;

  typedef enum logic {
    MODE_GEN,
    MODE_MISR
  } lfsr_mode_e;

  localparam logic [15:0] POLY_16       = 16'h6801;
  // Fibonacci taps x^16+x^14+x^13+x^11+1 -> register bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam logic [15:0] MISR_SEED_DEF = 16'h0000;
  localparam logic [15:0] GOLDEN_DEF    = 16'h0000;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] v, input logic din);
    return {v[14:0], 1'b0} ^ (v[15] ? POLY_16 : 16'h0000) ^ {15'b0, din};
  endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit shift register usable as a pattern generator or as a serial-input MISR.
module bist_lfsr16
  import bist_pkg::*;
#(
  parameter lfsr_mode_e  MODE = MODE_GEN,
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        enable,
  input  logic        serial_in,
  output logic [15:0] value
);

  logic [15:0] step_c;

  always_comb begin
    if (MODE == MODE_MISR) step_c = misr_step(value, serial_in);
    else                   step_c = lfsr_step(value);
  end

  always_ff @(posedge clock) begin
    if (reset || load) value <= SEED;
    else if (enable)   value <= step_c;
  end

endmodule

// File: rtl/scan_bist_ctrl.sv
// Pattern-side scan BIST controller: drives the CUT scan chain and primary inputs,
// compacts scan_out into a MISR and compares the final signature with GOLDEN.
module scan_bist_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 12,
  parameter int unsigned NUM_PAT   = 64,
  parameter int unsigned PI_W      = 5,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
  parameter logic [15:0] MISR_SEED = MISR_SEED_DEF,
  parameter logic [15:0] GOLDEN    = GOLDEN_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            scan_out,
  output logic            scan_en,
  output logic            scan_in,
  output logic            cut_reset,
  output logic [PI_W-1:0] pi_vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     signature
);

  localparam int unsigned BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PAT_W = $clog2(NUM_PAT + 1);

  bist_state_e      state, state_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_nxt;
  logic [PAT_W-1:0] pat_cnt, pat_nxt;

  logic             gen_load, gen_en, misr_load, misr_en;
  logic [15:0]      gen_q;
  logic             unused_gen;

  logic             scan_en_d, scan_in_d, cut_reset_d, busy_d, done_d, pass_d;
  logic [PI_W-1:0]  pi_vec_d;

  // Generator runs one cycle ahead so scan_in/pi_vec can be registered straight from it.
  bist_lfsr16 #(.MODE(MODE_GEN), .SEED(LFSR_SEED)) u_gen (
    .clock     (clock),
    .reset     (reset),
    .load      (gen_load),
    .enable    (gen_en),
    .serial_in (1'b0),
    .value     (gen_q)
  );

  bist_lfsr16 #(.MODE(MODE_MISR), .SEED(MISR_SEED)) u_misr (
    .clock     (clock),
    .reset     (reset),
    .load      (misr_load),
    .enable    (misr_en),
    .serial_in (scan_out),
    .value     (signature)
  );

  assign unused_gen = ^gen_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      pat_cnt   <= '0;
      scan_en   <= 1'b0;
      scan_in   <= 1'b0;
      cut_reset <= 1'b0;
      pi_vec    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_nxt;
      pat_cnt   <= pat_nxt;
      scan_en   <= scan_en_d;
      scan_in   <= scan_in_d;
      cut_reset <= cut_reset_d;
      pi_vec    <= pi_vec_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
    end
  end

  // Sequencing and shift/pattern counters.
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    pat_nxt   = pat_cnt;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_INIT;
      ST_INIT: begin
        misr_load = 1'b1;
        bit_nxt   = '0;
        pat_nxt   = '0;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT, ST_UNLOAD: begin
        misr_en = 1'b1;
        if (bit_cnt == BIT_W'(CHAIN_LEN - 1)) begin
          bit_nxt   = '0;
          state_nxt = (state == ST_SHIFT) ? ST_CAPTURE : ST_COMPARE;
        end else begin
          bit_nxt = bit_cnt + BIT_W'(1);
        end
      end
      ST_CAPTURE: begin
        pat_nxt   = pat_cnt + PAT_W'(1);
        state_nxt = (pat_cnt == PAT_W'(NUM_PAT - 1)) ? ST_UNLOAD : ST_SHIFT;
      end
      ST_COMPARE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output register inputs, decoded from the state being entered.
  always_comb begin
    gen_load    = (state_nxt == ST_INIT);
    gen_en      = (state_nxt == ST_SHIFT);
    scan_en_d   = (state_nxt == ST_SHIFT) || (state_nxt == ST_UNLOAD);
    scan_in_d   = (state_nxt == ST_SHIFT) && gen_q[15];
    cut_reset_d = (state_nxt == ST_INIT);
    busy_d      = (state_nxt != ST_IDLE);
    pi_vec_d    = (state_nxt == ST_CAPTURE) ? gen_q[PI_W-1:0] : pi_vec;
    done_d      = done;
    pass_d      = pass;
    if (state == ST_COMPARE) begin
      done_d = 1'b1;
      pass_d = (signature == GOLDEN);
    end
    if (state_nxt == ST_INIT) begin
      done_d = 1'b0;
      pass_d = 1'b0;
    end
  end

endmodule
